// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products into one saturating result,
// taking products and delivering results over valid/ready handshakes.
module product_accumulator #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 12,
    parameter int COUNT = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sat, sat_next;
    logic             out_valid_next;
    logic [ACC_W-1:0] out_sum_next;
    logic             out_ovf_next;

    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum_wide;
    logic             sat_hit;
    logic [ACC_W-1:0] acc_sat;

    assign in_ready = (state == ACC) & ~clear & ~rst;
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CNT_W'(COUNT - 1));

    // One extra bit catches the carry out; saturation is sticky for the block.
    assign sum_wide = {1'b0, acc} + (ACC_W + 1)'(in_p);
    assign sat_hit  = sat | sum_wide[ACC_W];
    assign acc_sat  = sat_hit ? '1 : sum_wide[ACC_W-1:0];

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = cnt;
        sat_next       = sat;
        out_valid_next = out_valid;
        out_sum_next   = out_sum;
        out_ovf_next   = out_ovf;
        case (state)
            ACC: begin
                if (clear) begin
                    acc_next = '0;
                    cnt_next = '0;
                    sat_next = 1'b0;
                end else if (accept) begin
                    if (last) begin
                        out_sum_next   = acc_sat;
                        out_ovf_next   = sat_hit;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        sat_next       = 1'b0;
                        state_next     = HOLD;
                    end else begin
                        acc_next = acc_sat;
                        sat_next = sat_hit;
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // clear is deliberately ignored here so the pending result survives.
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            sat       <= sat_next;
            out_valid <= out_valid_next;
            out_sum   <= out_sum_next;
            out_ovf   <= out_ovf_next;
        end
    end

endmodule
